uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester byte scheduler feeding a UART transmitter.
// Each accepted byte goes through SEND (offered to the transmitter) and WAIT
// (frame on the wire). Only then does the next arbitration happen. A burst
// limit stops one requester from starving the other. A WAIT timeout abandons
// a frame whose tx_done_i never arrives.
//
// Handshakes:
//   requester side : req_valid_i[n] is a level request. req_ready_o[n] pulses
//                    combinationally, in IDLE only, for the single winner.
//                    The byte on req_data<n>_i is taken on that clock edge.
//   transmitter side: tx_valid_o/tx_data_o stay stable until the edge where
//                    tx_valid_o && tx_ready_i. tx_done_i is looked at only in
//                    WAIT, so a done pulse seen during SEND is ignored.
module uart_tx_sched #(
  parameter int unsigned BURST_MAX      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [1:0] req_valid_i,
  input  logic [7:0] req_data0_i,
  input  logic [7:0] req_data1_i,
  output logic [1:0] req_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  input  logic       tx_done_i,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0]  BURST_LIM = 4'(BURST_MAX);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_win;    // index of the most recent winner
  logic [3:0]  burst_cnt;   // consecutive grants to last_win, 0 = no burst yet
  logic [15:0] tmo_cnt;     // cycles spent in the current WAIT
  logic [1:0]  grant_q;

  logic        win;
  logic        keep_last;
  logic        accept;
  logic        tmo_hit;
  logic [1:0]  ready_int;

  // Arbitration: the current owner keeps the line while its burst is open.
  // burst_cnt == 0 means no burst has started. This covers the state after
  // reset, where last_win is 1 so requester 0 takes the first tie.
  always_comb begin
    keep_last = req_valid_i[last_win] && (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM);
    if (keep_last) begin
      win = last_win;
    end else if (req_valid_i[!last_win]) begin
      win = !last_win;
    end else begin
      win = last_win;
    end
  end

  // Next-state and handshake decode; done beats the timeout when both land together.
  always_comb begin
    state_nxt = state;
    ready_int = 2'b00;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((req_valid_i != 2'b00) && RSTN) begin
          accept    = 1'b1;
          ready_int = win ? 2'b10 : 2'b01;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte latch, owner tracking and burst counting on each accept.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tx_data_o <= 8'h00;
      grant_q   <= 2'b00;
      last_win  <= 1'b1;
      burst_cnt <= 4'd0;
    end else if (accept) begin
      tx_data_o <= win ? req_data1_i : req_data0_i;
      grant_q   <= win ? 2'b10 : 2'b01;
      last_win  <= win;
      if (win == last_win) begin
        if (burst_cnt < BURST_LIM) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= 4'd1;
      end
    end else if ((state == ST_WAIT) && (state_nxt == ST_IDLE)) begin
      grant_q <= 2'b00;
    end
  end

  // WAIT cycle counter. It is held at zero outside WAIT, so each WAIT starts from 0.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tmo_cnt <= 16'd0;
    end else if (state == ST_WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= 16'd0;
    end
  end

  // One-cycle error pulse in the first IDLE cycle after an abandoned frame.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= tmo_hit;
    end
  end

  // Outputs derived from registered state. Accept pulses are suppressed while reset is held.
  always_comb begin
    req_ready_o = ready_int;
    tx_valid_o  = (state == ST_SEND);
    busy_o      = (state != ST_IDLE);
    grant_o     = grant_q;
  end

endmodule
